// File: rtl/ysyx_25060170_ctrl_pkg.sv
// Shared types for the core sequencer: state encodings, decode-class bit positions
// and the Moore output decode used to build the registered stage enables.
package ysyx_25060170_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_e;

   localparam int CLS_W      = 4;
   localparam int CLS_LOAD   = 0;
   localparam int CLS_STORE  = 1;
   localparam int CLS_REGW   = 2;
   localparam int CLS_EBREAK = 3;

   typedef struct packed {
      logic ifu_req;
      logic idu_go;
      logic exu_valid;
      logic lsu_req;
      logic lsu_we;
      logic reg_we;
      logic pc_we;
      logic halt;
      logic err;
   } ctrl_out_t;

   function automatic ctrl_out_t decode_outputs(input state_e st, input logic [CLS_W-1:0] cls);
      ctrl_out_t o;
      o = '0;
      case (st)
         S_FETCH:  o.ifu_req   = 1'b1;
         S_DECODE: o.idu_go    = 1'b1;
         S_EXEC:   o.exu_valid = 1'b1;
         S_MEM: begin
            o.lsu_req = 1'b1;
            o.lsu_we  = cls[CLS_STORE];
         end
         S_WB: begin
            o.reg_we = cls[CLS_REGW];
            o.pc_we  = 1'b1;
         end
         // HALT is only ever entered with the ebreak class bit latched
         S_HALT:   o.halt = cls[CLS_EBREAK];
         S_ERR:    o.err  = 1'b1;
         default:  o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/ysyx_25060170_core_ctrl_if.sv
// Handshake/stage-enable bundle between the core sequencer (master) and the
// IFU/IDU/GPR/EXU/LSU blocks it drives (slave).
interface ysyx_25060170_core_ctrl_if;
   logic ifu_req_o;
   logic ifu_rvalid_i;
   logic idu_go_o;
   logic gpr_ready_i;
   logic is_load_i;
   logic is_store_i;
   logic regw_i;
   logic ebreak_i;
   logic exu_valid_o;
   logic lsu_req_o;
   logic lsu_we_o;
   logic lsu_done_i;
   logic reg_we_o;
   logic pc_we_o;
   logic halt_o;
   logic err_o;

   modport master (
      output ifu_req_o, idu_go_o, exu_valid_o, lsu_req_o, lsu_we_o,
             reg_we_o, pc_we_o, halt_o, err_o,
      input  ifu_rvalid_i, gpr_ready_i, is_load_i, is_store_i, regw_i,
             ebreak_i, lsu_done_i
   );

   modport slave (
      input  ifu_req_o, idu_go_o, exu_valid_o, lsu_req_o, lsu_we_o,
             reg_we_o, pc_we_o, halt_o, err_o,
      output ifu_rvalid_i, gpr_ready_i, is_load_i, is_store_i, regw_i,
             ebreak_i, lsu_done_i
   );
endinterface

// File: rtl/ysyx_25060170_timeout_cnt.sv
// Bus-wait watchdog: counts stalled cycles; expired flags the cycle in which the
// count reaches TIMEOUT, so the FSM can still let a same-cycle response win.
module ysyx_25060170_timeout_cnt #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // next count: clear on state change, otherwise step while stalled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + TO_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/ysyx_25060170_core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with registered stage enables.
// Optional YSYX_25060170_CTRL_PERF_EN adds cycle and retired-instruction counters.
module ysyx_25060170_core_ctrl
   import ysyx_25060170_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8,
   parameter int CNT_W   = 32
) (
   input  logic clk,
   input  logic rst,
   ysyx_25060170_core_ctrl_if.master bus
`ifdef YSYX_25060170_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt_o,
   output logic [CNT_W-1:0] inst_cnt_o
`endif
);

   state_e           state_q, state_d;
   logic [CLS_W-1:0] class_q, class_d;
   ctrl_out_t        out_q, out_d;
   logic             to_en_s;
   logic             to_clr_s;
   logic             to_expired_s;

   assign to_en_s  = ((state_q == S_FETCH) && !bus.ifu_rvalid_i) ||
                     ((state_q == S_MEM)   && !bus.lsu_done_i);
   assign to_clr_s = (state_d != state_q);

   ysyx_25060170_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (to_clr_s),
      .en      (to_en_s),
      .expired (to_expired_s)
   );

   // next state and class latch; a response always beats a same-cycle expiry
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (bus.ifu_rvalid_i) begin
               state_d = S_DECODE;
            end else if (to_expired_s) begin
               state_d = S_ERR;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if (bus.gpr_ready_i) begin
               class_d[CLS_LOAD]   = bus.is_load_i;
               class_d[CLS_STORE]  = bus.is_store_i;
               class_d[CLS_REGW]   = bus.regw_i;
               class_d[CLS_EBREAK] = bus.ebreak_i;
               state_d = bus.ebreak_i ? S_HALT : S_EXEC;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_EXEC: begin
            if (class_q[CLS_LOAD] || class_q[CLS_STORE]) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (bus.lsu_done_i) begin
               state_d = S_WB;
            end else if (to_expired_s) begin
               state_d = S_ERR;
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs are decoded from the next state so they register in step with it
   always_comb begin
      out_d = decode_outputs(state_d, class_d);
   end

   // state, class and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         class_q <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         out_q   <= out_d;
      end
   end

   assign bus.ifu_req_o   = out_q.ifu_req;
   assign bus.idu_go_o    = out_q.idu_go;
   assign bus.exu_valid_o = out_q.exu_valid;
   assign bus.lsu_req_o   = out_q.lsu_req;
   assign bus.lsu_we_o    = out_q.lsu_we;
   assign bus.reg_we_o    = out_q.reg_we;
   assign bus.pc_we_o     = out_q.pc_we;
   assign bus.halt_o      = out_q.halt;
   assign bus.err_o       = out_q.err;

`ifdef YSYX_25060170_CTRL_PERF_EN
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

   // perf counters: active cycles and retirements, both wrapping
   always_comb begin
      cyc_cnt_d  = cyc_cnt_q;
      inst_cnt_d = inst_cnt_q;
      if ((state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR)) begin
         cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
      end else begin
         cyc_cnt_d = cyc_cnt_q;
      end
      if (state_q == S_WB) begin
         inst_cnt_d = inst_cnt_q + CNT_W'(1);
      end else begin
         inst_cnt_d = inst_cnt_q;
      end
   end

   // perf counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt_q  <= '0;
         inst_cnt_q <= '0;
      end else begin
         cyc_cnt_q  <= cyc_cnt_d;
         inst_cnt_q <= inst_cnt_d;
      end
   end

   assign cyc_cnt_o  = cyc_cnt_q;
   assign inst_cnt_o = inst_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25060170_core_ctrl.sv
// Directed bench for the core sequencer: a table of instruction shapes with
// hand-computed latencies, plus sequences for timeout, halt and mid-MEM reset.
module tb_ysyx_25060170_core_ctrl;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   ysyx_25060170_core_ctrl_if bus ();

`ifdef YSYX_25060170_CTRL_PERF_EN
   logic [31:0] cyc_cnt;
   logic [31:0] inst_cnt;
`endif

   ysyx_25060170_core_ctrl #(
      .TIMEOUT (4),
      .TO_W    (8),
      .CNT_W   (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef YSYX_25060170_CTRL_PERF_EN
      ,
      .cyc_cnt_o  (cyc_cnt),
      .inst_cnt_o (inst_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic ld;
      logic st;
      logic rw;
      int   rv_w;
      int   gpr_w;
      int   dn_w;
      int   lat;
      int   lsu_n;
      logic lsu_we;
      int   regwe_n;
   } vec_t;

   vec_t tbl[7];

   // {ifu_req, idu_go, exu_valid, lsu_req, lsu_we, reg_we, pc_we, halt, err}
   function automatic logic [8:0] outs();
      return {bus.ifu_req_o, bus.idu_go_o, bus.exu_valid_o, bus.lsu_req_o, bus.lsu_we_o,
              bus.reg_we_o, bus.pc_we_o, bus.halt_o, bus.err_o};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clr_in();
      bus.ifu_rvalid_i = 1'b0;
      bus.gpr_ready_i  = 1'b0;
      bus.is_load_i    = 1'b0;
      bus.is_store_i   = 1'b0;
      bus.regw_i       = 1'b0;
      bus.ebreak_i     = 1'b0;
      bus.lsu_done_i   = 1'b0;
   endtask

   task automatic do_reset();
      clr_in();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Called at a sample point in FETCH; runs one instruction up to the next FETCH.
   task automatic run_vec(input int i);
      vec_t v;
      int   cyc;
      int   fn;
      int   dn;
      int   mn;
      int   exu_n;
      int   regwe_n;
      int   lat;
      logic we_seen;
      logic done;
      v = tbl[i];
      cyc = 0; fn = 0; dn = 0; mn = 0; exu_n = 0; regwe_n = 0; lat = 0;
      we_seen = 1'b0;
      done = 1'b0;
      bus.is_load_i  = v.ld;
      bus.is_store_i = v.st;
      bus.regw_i     = v.rw;
      bus.ebreak_i   = 1'b0;
      while (!done && (cyc < 40)) begin
         cyc++;
         if (bus.ifu_req_o) fn++;
         if (bus.idu_go_o) dn++;
         if (bus.lsu_req_o) begin
            mn++;
            we_seen = we_seen | bus.lsu_we_o;
         end
         exu_n   += int'(bus.exu_valid_o);
         regwe_n += int'(bus.reg_we_o);
         bus.ifu_rvalid_i = bus.ifu_req_o && (fn > v.rv_w);
         bus.gpr_ready_i  = bus.idu_go_o  && (dn > v.gpr_w);
         bus.lsu_done_i   = bus.lsu_req_o && (mn > v.dn_w);
         if (bus.pc_we_o) begin
            done = 1'b1;
            lat  = cyc;
         end
         @(posedge clk);
         #1;
      end
      check($sformatf("v%0d_complete", i), 32'(done), 32'd1);
      check($sformatf("v%0d_latency", i), lat, v.lat);
      check($sformatf("v%0d_lsu_cycles", i), mn, v.lsu_n);
      check($sformatf("v%0d_lsu_we", i), 32'(we_seen), 32'(v.lsu_we));
      check($sformatf("v%0d_reg_we", i), regwe_n, v.regwe_n);
      check($sformatf("v%0d_exu_pulses", i), exu_n, 32'd1);
      check($sformatf("v%0d_next_fetch", i), 32'(outs()), 32'h100);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      logic [8:0] acc;
      logic       err_and;
      n_chk  = 0;
      n_fail = 0;
      //          ld    st    rw    rv gpr dn lat lsu we    regwe
      tbl[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 4,  0, 1'b0, 1};  // addi
      tbl[1] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 4,  0, 1'b0, 0};  // branch
      tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 0, 3, 8,  4, 1'b0, 1};  // lw, done races expiry
      tbl[3] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 5,  1, 1'b1, 0};  // sw
      tbl[4] = '{1'b0, 1'b0, 1'b1, 2, 1, 0, 7,  0, 1'b0, 1};  // slow fetch + gpr
      tbl[5] = '{1'b1, 1'b0, 1'b1, 3, 0, 2, 10, 3, 1'b0, 1};  // rvalid races expiry
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1, 2, 1, 9,  2, 1'b1, 0};  // sw with waits

      clr_in();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", 32'(outs()), 32'h000);
`ifdef YSYX_25060170_CTRL_PERF_EN
      check("reset_cyc_cnt", cyc_cnt, 32'd0);
      check("reset_inst_cnt", inst_cnt, 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("first_fetch", 32'(outs()), 32'h100);

      for (int i = 0; i < 7; i++) begin
         run_vec(i);
         check($sformatf("v%0d_no_err", i), 32'(bus.err_o), 32'd0);
      end

      // ebreak: HALT next cycle, EXU never fires, spurious responses ignored
      bus.ebreak_i     = 1'b1;
      bus.ifu_rvalid_i = 1'b1;
      @(posedge clk);
      #1;
      check("halt_decode", 32'(outs()), 32'h080);
      bus.ifu_rvalid_i = 1'b0;
      bus.gpr_ready_i  = 1'b1;
      @(posedge clk);
      #1;
      check("halt_entry", 32'(outs()), 32'h002);
      acc = '0;
      for (int k = 0; k < 10; k++) begin
         bus.ifu_rvalid_i = k[0];
         bus.lsu_done_i   = ~k[0];
         bus.gpr_ready_i  = 1'b1;
         @(posedge clk);
         #1;
         acc = acc | outs();
      end
      check("halt_sticky", 32'(acc), 32'h002);

      // fetch timeout with TIMEOUT=4: ERR on the 5th cycle after FETCH entry
      do_reset();
      for (int k = 1; k < 4; k++) begin
         @(posedge clk);
         #1;
      end
      check("to_last_fetch", 32'(outs()), 32'h100);
      @(posedge clk);
      #1;
      check("to_err", 32'(outs()), 32'h001);
      acc = '0;
      err_and = 1'b1;
      for (int k = 0; k < 100; k++) begin
         bus.ifu_rvalid_i = k[0];
         bus.lsu_done_i   = 1'b1;
         bus.gpr_ready_i  = 1'b1;
         @(posedge clk);
         #1;
         acc = acc | (outs() & 9'h1FE);
         err_and = err_and & bus.err_o;
      end
      check("err_sticky", 32'(err_and), 32'd1);
      check("err_enables_off", 32'(acc), 32'h000);

      // reset asserted while waiting in MEM
      do_reset();
      bus.is_load_i    = 1'b1;
      bus.regw_i       = 1'b1;
      bus.ifu_rvalid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ifu_rvalid_i = 1'b0;
      bus.gpr_ready_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.gpr_ready_i  = 1'b0;
      @(posedge clk);
      #1;
      check("mem_before_rst", 32'(outs()), 32'h020);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_outs", 32'(outs()), 32'h000);
`ifdef YSYX_25060170_CTRL_PERF_EN
      check("rst_cyc_cnt", cyc_cnt, 32'd0);
      check("rst_inst_cnt", inst_cnt, 32'd0);
`endif
      clr_in();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("idle_after_rst", 32'(outs()), 32'h000);
      @(posedge clk);
      #1;
      check("fetch_after_rst", 32'(outs()), 32'h100);
      for (int k = 0; k < 3; k++) begin
         run_vec(0);
      end
`ifdef YSYX_25060170_CTRL_PERF_EN
      check("perf_inst_cnt", inst_cnt, 32'd3);
      check("perf_cyc_cnt", cyc_cnt, 32'd12);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
